// File: rtl/vga_sync_rx.sv
// VGA receive timing recovery: locks onto hsync/vsync and regenerates sx/sy/de with the sampled colour.
// Latency 2 clocks pin-to-output; no backpressure, one pixel accepted every clock.
`timescale 1ns/1ps
module vga_sync_rx #(
  parameter int CORDW        = 10,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter bit SYNC_POL     = 1'b0,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [3:0]       vga_r,
  input  logic [3:0]       vga_g,
  input  logic [3:0]       vga_b,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic [3:0]       pix_r,
  output logic [3:0]       pix_g,
  output logic [3:0]       pix_b,
  output logic             locked,
  output logic             frame_start,
  output logic             sync_err
);

  localparam int WDW = $clog2(2*H_TOTAL) + 1;
  localparam int GW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [CORDW-1:0] HSS    = CORDW'(H_SYNC_START);
  localparam logic [CORDW-1:0] VSS    = CORDW'(V_SYNC_START);
  localparam logic [CORDW-1:0] HMAX   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VMAX   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] HRES_C = CORDW'(H_RES);
  localparam logic [CORDW-1:0] VRES_C = CORDW'(V_RES);
  localparam logic [WDW-1:0]   WD_LIM = WDW'(2*H_TOTAL);
  localparam logic [GW-1:0]    G_LIM  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic             hs1_q, hs2_q, vs1_q, vs2_q;
  logic [3:0]       r1_q, g1_q, b1_q;
  logic [CORDW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CORDW-1:0] hcnt_cur, vcnt_cur;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [CORDW-1:0] sx_q, sy_q;
  logic             de_q, de_d, fs_q, fs_d, err_q, err_d;
  logic [3:0]       pr_q, pg_q, pb_q;

  logic hs_edge, vs_edge, mismatch, timeout, load_h, load_v, line_end, lock_d;

  assign hs_edge  = (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
  assign vs_edge  = (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);
  assign timeout  = !hs_edge && (wd_q >= WD_LIM);
  // A coincident hs/vs edge is judged by the vsync rule alone.
  assign mismatch = vs_edge ? ((vcnt_q != VSS) || (hcnt_q != '0))
                            : (hs_edge && (hcnt_q != HSS));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    load_h  = 1'b0;
    load_v  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          load_v  = 1'b1;
          good_d  = '0;
          state_d = ALIGN;
        end else if (hs_edge) begin
          load_h = 1'b1;
        end
      end
      ALIGN: begin
        if (mismatch || timeout) begin
          state_d = SEARCH;
          load_v  = mismatch && vs_edge;
          load_h  = mismatch && !vs_edge;
        end else if (vs_edge) begin
          good_d = good_q + GW'(1);
          if (good_d == G_LIM) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch || timeout) begin
          err_d   = 1'b1;
          state_d = SEARCH;
          load_v  = mismatch && vs_edge;
          load_h  = mismatch && !vs_edge;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Coordinate of the pixel currently held in s1, after any re-load.
  always_comb begin
    hcnt_cur = load_v ? '0 : (load_h ? HSS : hcnt_q);
    vcnt_cur = load_v ? VSS : vcnt_q;
    line_end = (hcnt_cur == HMAX);
    hcnt_d   = line_end ? '0 : hcnt_cur + CORDW'(1);
    vcnt_d   = line_end ? ((vcnt_cur == VMAX) ? '0 : vcnt_cur + CORDW'(1)) : vcnt_cur;
    wd_d     = hs_edge ? WDW'(1) : ((wd_q >= WD_LIM) ? wd_q : wd_q + WDW'(1));
    lock_d   = (state_d == LOCKED);
    de_d     = lock_d && (hcnt_cur < HRES_C) && (vcnt_cur < VRES_C);
    fs_d     = lock_d && (hcnt_cur == '0) && (vcnt_cur == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
      hs1_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      wd_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
      pr_q    <= '0;
      pg_q    <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      hs1_q   <= hsync;
      hs2_q   <= hs1_q;
      vs1_q   <= vsync;
      vs2_q   <= vs1_q;
      r1_q    <= vga_r;
      g1_q    <= vga_g;
      b1_q    <= vga_b;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      wd_q    <= wd_d;
      sx_q    <= hcnt_cur;
      sy_q    <= vcnt_cur;
      de_q    <= de_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
      pr_q    <= de_d ? r1_q : 4'h0;
      pg_q    <= de_d ? g1_q : 4'h0;
      pb_q    <= de_d ? b1_q : 4'h0;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign pix_r       = pr_q;
  assign pix_g       = pg_q;
  assign pix_b       = pb_q;
  assign locked      = (state_q == LOCKED);
  assign frame_start = fs_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with a reduced raster: scenario table plus a per-pixel reference model.
`timescale 1ns/1ps
module tb_vga_sync_rx;
  localparam int CW = 10, HRES = 16, HSS = 18, HSW = 3, HT = 24;
  localparam int VRES = 8, VSS = 10, VSW = 2, VT = 13, LF = 2;
  localparam bit POL = 1'b0;
  localparam int WX = 5, WY = 3;

  logic clk = 1'b0;
  logic reset_n, hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b, pix_r, pix_g, pix_b;
  logic [CW-1:0] sx, sy;
  logic de, locked, frame_start, sync_err;

  always #5 clk = ~clk;

  vga_sync_rx #(.CORDW(CW), .H_RES(HRES), .V_RES(VRES), .H_SYNC_START(HSS),
                .V_SYNC_START(VSS), .H_TOTAL(HT), .V_TOTAL(VT), .SYNC_POL(POL),
                .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .sx(sx), .sy(sy), .de(de),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err));

  typedef struct {int frame; int gh; int gv; bit chk_xy; int sx; int sy; bit de;
                  logic [11:0] pix; bit locked; bit fs; bit err;} exp_t;
  typedef struct {int sx; int sy; bit de; logic [11:0] pix;} obs_t;
  // fault: 0 none, 1 one hsync late by a clock, 2 two hsync pulses missing,
  //        3 async reset mid-line, 4 extra hsync pulse coincident with vsync
  typedef struct {int ht; int vt; int fault; int frames; bit white;
                  int first_lk; int last_lk; bit lk_end; int errs; int fs;} scn_t;

  exp_t expq[$];
  int checks = 0, errors = 0;

  // Reference model state: linear raster position and plain integer bookkeeping.
  int m_mode, m_good, m_pos, m_since;
  bit m_hprev, m_vprev, m_known;

  int mm_cnt, mm_frame, mm_gh, mm_gv, n_err, n_fs, first_rise, last_rise, rise_h, rise_v;
  bit prev_lk;
  obs_t w_obs[3];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_pos = 1; m_since = 1;
    m_hprev = 1'b0; m_vprev = 1'b0; m_known = 1'b0;
  endtask

  task automatic model_step(input bit h, input bit v, input logic [11:0] rgb,
                            input int fr, input int gh, input int gv);
    bit hse, vse, mis, tmo, err;
    int cur;
    exp_t e;
    hse = (h == POL) && (m_hprev != POL);
    vse = (v == POL) && (m_vprev != POL);
    m_hprev = h; m_vprev = v;
    cur = m_pos; err = 1'b0;
    tmo = !hse && (m_since >= 2*HT);
    if (vse) mis = (cur != VSS*HT);
    else if (hse) mis = ((cur % HT) != HSS);
    else mis = 1'b0;
    if (m_mode == 0) begin
      if (vse) begin cur = VSS*HT; m_known = 1'b1; m_good = 0; m_mode = 1; end
      else if (hse) cur = (cur / HT) * HT + HSS;
    end else if (mis || tmo) begin
      err = (m_mode == 2);
      m_mode = 0;
      if (mis) cur = vse ? VSS*HT : (cur / HT) * HT + HSS;
    end else if (vse && m_mode == 1) begin
      m_good++;
      if (m_good == LF) m_mode = 2;
    end
    m_since = hse ? 1 : m_since + 1;
    e.frame = fr; e.gh = gh; e.gv = gv; e.chk_xy = m_known;
    e.locked = (m_mode == 2);
    e.sx = cur % HT; e.sy = cur / HT;
    e.de = e.locked && e.sx < HRES && e.sy < VRES;
    e.pix = e.de ? rgb : 12'h000;
    e.fs = e.locked && cur == 0;
    e.err = err;
    m_pos = (cur + 1) % (HT*VT);
    expq.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    bit bad;
    e = expq.pop_front();
    bad = (locked !== e.locked) || (de !== e.de) || ({pix_r, pix_g, pix_b} !== e.pix) ||
          (frame_start !== e.fs) || (sync_err !== e.err) ||
          (e.chk_xy && ((sx !== CW'(e.sx)) || (sy !== CW'(e.sy))));
    if (bad) begin
      if (mm_cnt == 0) begin mm_frame = e.frame; mm_gh = e.gh; mm_gv = e.gv; end
      mm_cnt++;
    end
    if (sync_err === 1'b1) n_err++;
    if (frame_start === 1'b1) n_fs++;
    if (locked === 1'b1 && !prev_lk) begin
      if (first_rise < 0) begin first_rise = e.frame; rise_h = e.gh; rise_v = e.gv; end
      last_rise = e.frame;
    end
    prev_lk = (locked === 1'b1);
    if (e.frame == 3 && e.gv == WY && e.gh >= WX-1 && e.gh <= WX+1) begin
      w_obs[e.gh-WX+1].sx  = int'(sx);
      w_obs[e.gh-WX+1].sy  = int'(sy);
      w_obs[e.gh-WX+1].de  = de;
      w_obs[e.gh-WX+1].pix = {pix_r, pix_g, pix_b};
    end
  endtask

  task automatic tick(input bit h, input bit v, input logic [11:0] rgb,
                      input int fr, input int gh, input int gv, input bit do_rst);
    @(negedge clk);
    if (expq.size() >= 2) compare_front();
    hsync = h; vsync = v; {vga_r, vga_g, vga_b} = rgb;
    if (do_rst) begin
      #2 reset_n = 1'b0;
      #1 check("async_reset_outputs",
               int'({sx, sy, de, pix_r, pix_g, pix_b, locked, frame_start, sync_err} != '0), 0);
      #1 reset_n = 1'b1;
      expq.delete();
      model_reset();
      prev_lk = 1'b0;
    end
    model_step(h, v, rgb, fr, gh, gv);
  endtask

  initial begin
    scn_t tbl[7];
    tbl[0] = '{HT,   VT,   0, 5, 1'b1,  2,  2, 1'b1, 0, 2};
    tbl[1] = '{HT,   VT,   1, 7, 1'b0,  2,  5, 1'b1, 1, 2};
    tbl[2] = '{HT,   VT,   2, 7, 1'b0,  2,  5, 1'b1, 1, 2};
    tbl[3] = '{HT+1, VT,   0, 5, 1'b0, -1, -1, 1'b0, 0, 0};
    tbl[4] = '{HT,   VT+1, 0, 5, 1'b0, -1, -1, 1'b0, 0, 0};
    tbl[5] = '{HT,   VT,   3, 7, 1'b0,  2,  5, 1'b1, 0, 2};
    tbl[6] = '{HT,   VT,   4, 5, 1'b0,  2,  2, 1'b1, 0, 2};

    reset_n = 1'b0; hsync = ~POL; vsync = ~POL; vga_r = '0; vga_g = '0; vga_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state_outputs",
             int'({sx, sy, de, pix_r, pix_g, pix_b, locked, frame_start, sync_err} != '0), 0);

    for (int s = 0; s < 7; s++) begin
      mm_cnt = 0; n_err = 0; n_fs = 0; first_rise = -1; last_rise = -1;
      rise_h = -1; rise_v = -1; prev_lk = 1'b0;
      for (int k = 0; k < 3; k++) w_obs[k] = '{-1, -1, 1'b0, 12'hxxx};
      expq.delete();
      for (int f = 0; f < tbl[s].frames; f++)
        for (int gv = 0; gv < tbl[s].vt; gv++)
          for (int gh = 0; gh < tbl[s].ht; gh++) begin
            bit hs_on, vs_on, rst;
            logic [11:0] rgb;
            hs_on = (gh >= HSS) && (gh < HSS + HSW);
            vs_on = (gv >= VSS) && (gv < VSS + VSW);
            if (tbl[s].fault == 1 && f == 3 && gv == 2) hs_on = (gh >= HSS+1) && (gh < HSS+HSW+1);
            if (tbl[s].fault == 2 && f == 3 && (gv == 2 || gv == 3)) hs_on = 1'b0;
            if (tbl[s].fault == 4 && gv == VSS && gh < 2) hs_on = 1'b1;
            if (tbl[s].white) rgb = (gh == WX && gv == WY) ? 12'hFFF : 12'h000;
            else rgb = 12'($urandom);
            rst = (f == 0 && gv == 0 && gh == 0) ||
                  (tbl[s].fault == 3 && f == 3 && gv == 4 && gh == HT/2);
            tick(hs_on ? POL : ~POL, vs_on ? POL : ~POL, rgb, f, gh, gv, rst);
          end
      tick(~POL, ~POL, 12'h000, tbl[s].frames, 0, 0, 1'b0);
      tick(~POL, ~POL, 12'h000, tbl[s].frames, 1, 0, 1'b0);

      check($sformatf("s%0d_model_diff_cycles", s), mm_cnt, 0);
      if (mm_cnt != 0)
        $display("  s%0d first divergence at frame %0d pixel (%0d,%0d)", s, mm_frame, mm_gh, mm_gv);
      check($sformatf("s%0d_sync_err_pulses", s), n_err, tbl[s].errs);
      check($sformatf("s%0d_frame_start_pulses", s), n_fs, tbl[s].fs);
      check($sformatf("s%0d_locked_at_end", s), int'(prev_lk), int'(tbl[s].lk_end));
      check($sformatf("s%0d_first_lock_frame", s), first_rise, tbl[s].first_lk);
      check($sformatf("s%0d_last_lock_frame", s), last_rise, tbl[s].last_lk);

      if (s == 0) begin
        check("lock_rise_sx", rise_h, 0);
        check("lock_rise_sy", rise_v, VSS);
        check("white_sx", w_obs[1].sx, WX);
        check("white_sy", w_obs[1].sy, WY);
        check("white_de", int'(w_obs[1].de), 1);
        check("white_pix", int'(w_obs[1].pix), 'hFFF);
        check("left_neighbour_pix", int'(w_obs[0].pix), 0);
        check("right_neighbour_pix", int'(w_obs[2].pix), 0);
        check("right_neighbour_sx", w_obs[2].sx, WX+1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
